// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller driven by a debounced light sensor
// and two push buttons, all resynchronised into the clk domain.
module stopwatch_ctrl #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic       lap_req,
  input  logic       clear_req,
  output logic       run_en,
  output logic       clr_cnt,
  output logic       lap_hold,
  output logic       led0,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  logic [1:0]  sensor_sync_r;
  logic [1:0]  lap_sync_r;
  logic [1:0]  clear_sync_r;
  logic        filt_r;
  logic        filt_prev_r;
  logic        lap_prev_r;
  logic        clear_prev_r;
  logic [31:0] stab_cnt_r;
  logic        toggle_ev_r;
  logic        lap_ev_r;
  logic        clr_ev_r;
  state_t      state_r;
  state_t      next_state_s;
  logic        clr_accept_s;

  // Two-flop synchronisers; bit 1 is the only stage used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sensor_sync_r <= 2'b00;
      lap_sync_r    <= 2'b00;
      clear_sync_r  <= 2'b00;
    end else begin
      sensor_sync_r <= {sensor_sync_r[0], sensor};
      lap_sync_r    <= {lap_sync_r[0], lap_req};
      clear_sync_r  <= {clear_sync_r[0], clear_req};
    end
  end

  // Stability filter: the count restarts whenever the input agrees with filt,
  // so it flips filt before it could ever pass DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r     <= 1'b0;
      stab_cnt_r <= 32'd0;
    end else if (sensor_sync_r[1] == filt_r) begin
      filt_r     <= filt_r;
      stab_cnt_r <= 32'd0;
    end else if (stab_cnt_r >= (DEBOUNCE_CYCLES - 32'd1)) begin
      filt_r     <= sensor_sync_r[1];
      stab_cnt_r <= 32'd0;
    end else begin
      filt_r     <= filt_r;
      stab_cnt_r <= stab_cnt_r + 32'd1;
    end
  end

  // Registered edge detectors producing single-cycle event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_prev_r  <= 1'b0;
      lap_prev_r   <= 1'b0;
      clear_prev_r <= 1'b0;
      toggle_ev_r  <= 1'b0;
      lap_ev_r     <= 1'b0;
      clr_ev_r     <= 1'b0;
    end else begin
      filt_prev_r  <= filt_r;
      lap_prev_r   <= lap_sync_r[1];
      clear_prev_r <= clear_sync_r[1];
      toggle_ev_r  <= filt_r ^ filt_prev_r;
      lap_ev_r     <= lap_sync_r[1] & ~lap_prev_r;
      clr_ev_r     <= clear_sync_r[1] & ~clear_prev_r;
    end
  end

  // Next-state decode: the highest-priority event present is the only one
  // considered, even when the current state ignores it.
  always_comb begin
    next_state_s = state_r;
    clr_accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_ev_r) begin
          clr_accept_s = 1'b1;
        end else if (toggle_ev_r) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (clr_ev_r) begin
          next_state_s = ST_RUN;
        end else if (toggle_ev_r) begin
          next_state_s = ST_PAUSE;
        end else if (lap_ev_r) begin
          next_state_s = ST_LAP;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (clr_ev_r) begin
          next_state_s = ST_IDLE;
          clr_accept_s = 1'b1;
        end else if (toggle_ev_r) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_PAUSE;
        end
      end
      ST_LAP: begin
        if (clr_ev_r) begin
          next_state_s = ST_LAP;
        end else if (toggle_ev_r) begin
          next_state_s = ST_PAUSE;
        end else if (lap_ev_r) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_LAP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        clr_accept_s = 1'b0;
      end
    endcase
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      run_en   <= 1'b0;
      lap_hold <= 1'b0;
      led0     <= 1'b0;
      clr_cnt  <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      run_en   <= (next_state_s == ST_RUN) || (next_state_s == ST_LAP);
      lap_hold <= (next_state_s == ST_LAP);
      led0     <= (next_state_s == ST_PAUSE);
      clr_cnt  <= clr_accept_s;
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: directed scenarios plus a
// randomized event sequence checked against a rule-level model.
module tb_stopwatch_ctrl;

  localparam logic [31:0] DB = 32'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor = 1'b0;
  logic       lap_req = 1'b0;
  logic       clear_req = 1'b0;
  logic       run_en;
  logic       clr_cnt;
  logic       lap_hold;
  logic       led0;
  logic [1:0] state;

  int   total = 0;
  int   bad = 0;
  int   clr_cycles = 0;
  int   m_state = 0;
  logic m_sensor = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sensor(sensor), .lap_req(lap_req),
    .clear_req(clear_req), .run_en(run_en), .clr_cnt(clr_cnt),
    .lap_hold(lap_hold), .led0(led0), .state(state)
  );

  always @(negedge clk) if (clr_cnt === 1'b1) clr_cycles++;

  // Expected {state, run_en, lap_hold, led0}; 0=IDLE 1=RUN 2=PAUSE 3=LAP.
  function automatic logic [4:0] exp_vec(int st);
    logic [1:0] s2;
    s2 = st[1:0];
    return {s2, (st == 1) || (st == 3), st == 3, st == 2};
  endfunction

  function automatic int model_next(int st, bit clr, bit tog, bit lap);
    if (clr) return (st == 2) ? 0 : st;
    if (tog) return (st == 1 || st == 3) ? 2 : 1;
    if (lap) return (st == 1) ? 3 : ((st == 3) ? 1 : st);
    return st;
  endfunction

  function automatic logic [4:0] obs();
    return {state, run_en, lap_hold, led0};
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses are one sample wide; the state reacts on the 4th edge.
  task automatic press_lap();
    lap_req = 1'b1; step(1); lap_req = 1'b0; step(3);
  endtask

  task automatic press_clear();
    clear_req = 1'b1; step(1); clear_req = 1'b0; step(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(3);
    total++;
    if ({obs(), clr_cnt} !== 6'd0) begin
      bad++; $display("FAIL reset_hold got=%b want=000000", {obs(), clr_cnt});
    end
    rst_n = 1'b1; step(10);
    total++;
    if (obs() !== exp_vec(0)) begin
      bad++; $display("FAIL reset_release got=%b want=%b", obs(), exp_vec(0));
    end
  endtask

  task automatic test_start();
    sensor = 1'b1; step(7);
    total++;
    if (obs() !== exp_vec(0)) begin
      bad++; $display("FAIL start_edge7 got=%b want=%b", obs(), exp_vec(0));
    end
    step(1);
    total++;
    if (obs() !== exp_vec(1)) begin
      bad++; $display("FAIL start_edge8 got=%b want=%b", obs(), exp_vec(1));
    end
  endtask

  task automatic test_bounce();
    bit dropped = 1'b0;
    sensor = 1'b0; step(3);
    sensor = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (run_en !== 1'b1 || state !== 2'b01) dropped = 1'b1;
    end
    total++;
    if (dropped !== 1'b0) begin
      bad++; $display("FAIL short_bounce got=left_run want=stay_run");
    end
  endtask

  task automatic test_lap();
    lap_req = 1'b1; step(1); lap_req = 1'b0; step(2);
    total++;
    if (obs() !== exp_vec(1)) begin
      bad++; $display("FAIL lap_edge3 got=%b want=%b", obs(), exp_vec(1));
    end
    step(1);
    total++;
    if (obs() !== exp_vec(3)) begin
      bad++; $display("FAIL lap_enter got=%b want=%b", obs(), exp_vec(3));
    end
    press_lap();
    total++;
    if (obs() !== exp_vec(1)) begin
      bad++; $display("FAIL lap_exit got=%b want=%b", obs(), exp_vec(1));
    end
  endtask

  task automatic test_lap_toggle_clear();
    int c0;
    press_lap(); step(2);
    sensor = 1'b0; step(8);
    total++;
    if (obs() !== exp_vec(2)) begin
      bad++; $display("FAIL lap_to_pause got=%b want=%b", obs(), exp_vec(2));
    end
    c0 = clr_cycles;
    press_clear(); step(5);
    total++;
    if (obs() !== exp_vec(0)) begin
      bad++; $display("FAIL pause_clear got=%b want=%b", obs(), exp_vec(0));
    end
    total++;
    if (clr_cycles - c0 !== 1) begin
      bad++; $display("FAIL clr_width got=%0d want=1", clr_cycles - c0);
    end
  endtask

  task automatic test_clear_coincide();
    int c0;
    bit saw_run = 1'b0;
    sensor = 1'b1; step(8);
    sensor = 1'b0; step(8);
    total++;
    if (obs() !== exp_vec(2)) begin
      bad++; $display("FAIL setup_pause got=%b want=%b", obs(), exp_vec(2));
    end
    c0 = clr_cycles;
    sensor = 1'b1; step(4);
    clear_req = 1'b1; step(1); clear_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (state === 2'b01) saw_run = 1'b1;
    end
    total++;
    if ({saw_run, obs()} !== {1'b0, exp_vec(0)}) begin
      bad++; $display("FAIL coincide got=%b want=%b", {saw_run, obs()}, {1'b0, exp_vec(0)});
    end
    total++;
    if (clr_cycles - c0 !== 1) begin
      bad++; $display("FAIL coincide_clr got=%0d want=1", clr_cycles - c0);
    end
  endtask

  task automatic test_reset_sensor_high();
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    step(7);
    total++;
    if (obs() !== exp_vec(0)) begin
      bad++; $display("FAIL high_rst_edge7 got=%b want=%b", obs(), exp_vec(0));
    end
    step(1);
    total++;
    if (obs() !== exp_vec(1)) begin
      bad++; $display("FAIL high_rst_edge8 got=%b want=%b", obs(), exp_vec(1));
    end
  endtask

  task automatic test_reset_midcount();
    int c0;
    bit moved = 1'b0;
    sensor = 1'b0; step(4);
    rst_n = 1'b0; #1;
    total++;
    if ({obs(), clr_cnt} !== 6'd0) begin
      bad++; $display("FAIL midcount_async got=%b want=000000", {obs(), clr_cnt});
    end
    step(1); rst_n = 1'b1;
    c0 = clr_cycles;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (obs() !== exp_vec(0)) moved = 1'b1;
    end
    total++;
    if ({moved, clr_cycles - c0} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL midcount_quiet got=moved%0d_clr%0d want=moved0_clr0", moved, clr_cycles - c0);
    end
  endtask

  task automatic test_random();
    int op;
    int len;
    int c0;
    int exp_clr;
    m_state = 0;
    m_sensor = 1'b0;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      c0 = clr_cycles;
      exp_clr = 0;
      case (op)
        0: begin
          m_sensor = ~m_sensor; sensor = m_sensor; step(12);
          m_state = model_next(m_state, 1'b0, 1'b1, 1'b0);
        end
        1: begin
          press_lap(); step(8);
          m_state = model_next(m_state, 1'b0, 1'b0, 1'b1);
        end
        2: begin
          exp_clr = (m_state == 0 || m_state == 2) ? 1 : 0;
          press_clear(); step(8);
          m_state = model_next(m_state, 1'b1, 1'b0, 1'b0);
        end
        default: begin
          len = $urandom_range(1, 3);
          sensor = ~m_sensor; step(len); sensor = m_sensor; step(12);
        end
      endcase
      total++;
      if ({obs(), clr_cycles - c0} !== {exp_vec(m_state), exp_clr}) begin
        bad++;
        $display("FAIL random_op%0d_n%0d got=%b/clr%0d want=%b/clr%0d",
                 op, n, obs(), clr_cycles - c0, exp_vec(m_state), exp_clr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_bounce();
    test_lap();
    test_lap_toggle_clear();
    test_clear_coincide();
    test_reset_sensor_high();
    test_reset_midcount();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 32'd500_000 (10 ms at 50 MHz), giving the sensor stability window in clk cycles; legal range 1 to 2^32-1.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sensor, input, 1 bit: raw luminance sensor level, asynchronous to clk, may bounce.
REQ-005 The block SHALL have port lap_req, input, 1 bit: asynchronous lap button, active high.
REQ-006 The block SHALL have port clear_req, input, 1 bit: asynchronous clear button, active high.
REQ-007 The block SHALL have port run_en, output, 1 bit: count enable to the time-of-day counter.
REQ-008 The block SHALL have port clr_cnt, output, 1 bit: one-cycle pulse that zeroes the counter.
REQ-009 The block SHALL have port lap_hold, output, 1 bit: freeze of the displayed time while counting continues.
REQ-010 The block SHALL have port led0, output, 1 bit: high only in PAUSE.
REQ-011 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-012 The block SHALL pass sensor, lap_req and clear_req each through a 2-flop synchronizer before any other use.
REQ-013 The block SHALL hold a filtered sensor level, filt, with these rules:
- filt changes only after the synchronized sensor has differed from filt for DEBOUNCE_CYCLES consecutive cycles.
- The 32-bit stability counter clears on any cycle where the synchronized sensor equals filt.
REQ-014 The block SHALL generate toggle_ev as a 1-cycle pulse the cycle after filt changes; the rising and falling edges of filt both produce an event.
REQ-015 The block SHALL generate lap_ev and clr_ev as 1-cycle pulses on the rising edges of the synchronized lap_req and clear_req; the buttons are not debounced.
REQ-016 The block SHALL update the FSM on the clk edge following an event pulse; run_en, lap_hold and led0 are registered decodes of the next state, so they change on the same edge as state.
REQ-017 The block SHALL apply event priority clr_ev > toggle_ev > lap_ev when events coincide; lower-priority events in that cycle are discarded.
REQ-018 The block SHALL implement these transitions in IDLE:
- toggle -> RUN.
- clr -> stay in IDLE and pulse clr_cnt.
- lap ignored.
REQ-019 The block SHALL implement these transitions in RUN:
- toggle -> PAUSE.
- lap -> LAP.
- clr ignored.
REQ-020 The block SHALL implement these transitions in PAUSE:
- toggle -> RUN.
- clr -> IDLE and pulse clr_cnt.
- lap ignored.
REQ-021 The block SHALL implement these transitions in LAP:
- lap -> RUN.
- toggle -> PAUSE, releasing lap_hold.
- clr ignored.
REQ-022 The block SHALL drive outputs per state:
- run_en = 1 in RUN and LAP only.
- lap_hold = 1 in LAP only.
- led0 = 1 in PAUSE only.
REQ-023 The block SHALL assert clr_cnt for exactly one cycle per accepted clear; run_en is 0 during that cycle.
REQ-024 The block SHALL give a clean sensor transition a latency of DEBOUNCE_CYCLES+4 clk edges, counted from the first edge that samples the new level, to the state change.
REQ-025 The block SHALL give a button press a latency of 4 clk edges from the first sampling edge to the state change.
REQ-026 The block SHALL restart the stability count from zero on any sensor bounce shorter than DEBOUNCE_CYCLES, and SHALL NOT produce a toggle event for it.
REQ-027 The block SHALL NOT saturate the stability counter; it never exceeds DEBOUNCE_CYCLES because filt updates first.

Reset
REQ-028 The block SHALL, while rst_n=0, asynchronously force:
- state=IDLE and all outputs to 0.
- synchronizer flops, filt and edge-detect registers to 0.
- the stability counter to 0.
REQ-029 The block SHALL discard a debounce count or event pulse in flight when reset asserts mid-operation; no event is produced after release from pre-reset activity.
REQ-030 The block SHALL have a sensor held high through reset release debounce normally, producing one toggle (IDLE->RUN) after DEBOUNCE_CYCLES+4 edges.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 The bench SHALL cover: reset release, then sensor 0->1 held -> state 00->01 and run_en 0->1 exactly 8 edges later; led0=0.
REQ-032 The bench SHALL cover: in RUN, sensor pulses 1->0 for 3 cycles then back to 1 -> no state change and run_en stays 1.
REQ-033 The bench SHALL cover: in RUN, lap_req pulse -> state=11 with lap_hold=1 and run_en=1; second lap_req -> state=01 with lap_hold=0.
REQ-034 The bench SHALL cover: in LAP, sensor toggle -> state=10 with led0=1, run_en=0, lap_hold=0; then clear_req -> state=00 with one clr_cnt pulse of exactly 1 cycle.
REQ-035 The bench SHALL cover: in PAUSE, clear_req synced to land on the same cycle as the toggle event -> state=00, clr_cnt pulses once, and no RUN entry.
REQ-036 The bench SHALL cover: in RUN with the debounce counter at 2, rst_n low for 1 cycle -> all outputs immediately 0 and state=00; with sensor static after release, no event occurs.
